memory_bus_ctrl: RTL

//  Bus master between CPU control unit and memory map of the 8-bit CPU. Takes one load/store

---
 rtl/membus_pkg.sv | 25 ++
 rtl/membus_decode.sv | 38 +++
 rtl/memory_bus_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/membus_pkg.sv
// Shared types and default memory-map boundaries for the CPU memory bus controller.
package membus_pkg;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RW,
        REG_OUT,
        REG_IN
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    localparam int unsigned ROM_TOP_DEF = 127;
    localparam int unsigned RW_TOP_DEF  = 223;
    localparam int unsigned OUT_TOP_DEF = 239;

    function automatic logic [7:0] addr_byte(input int unsigned v);
        return v[7:0];
    endfunction

endpackage

// File: rtl/membus_decode.sv
// Combinational address decoder: 8-bit byte address -> memory region and port index.
// Zero latency; no flow control.
module membus_decode
    import membus_pkg::*;
#(
    parameter int unsigned ROM_TOP = ROM_TOP_DEF,
    parameter int unsigned RW_TOP  = RW_TOP_DEF,
    parameter int unsigned OUT_TOP = OUT_TOP_DEF,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [7:0]       addr_i,
    output region_t          region_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [7:0] ROM_TOP_B = addr_byte(ROM_TOP);
    localparam logic [7:0] RW_TOP_B  = addr_byte(RW_TOP);
    localparam logic [7:0] OUT_TOP_B = addr_byte(OUT_TOP);
    localparam logic [7:0] OUT_BASE  = addr_byte(RW_TOP + 1);
    localparam logic [7:0] IN_BASE   = addr_byte(OUT_TOP + 1);

    // Regions are contiguous and ordered, so a priority chain of upper bounds is a full decode.
    always_comb begin
        region_o = REG_IN;
        idx_o    = IDX_W'(addr_i - IN_BASE);
        if (addr_i <= ROM_TOP_B) begin
            region_o = REG_ROM;
            idx_o    = '0;
        end else if (addr_i <= RW_TOP_B) begin
            region_o = REG_RW;
            idx_o    = '0;
        end else if (addr_i <= OUT_TOP_B) begin
            region_o = REG_OUT;
            idx_o    = IDX_W'(addr_i - OUT_BASE);
        end
    end

endmodule

// File: rtl/memory_bus_ctrl.sv
// CPU memory bus master over ROM / RW RAM / port regions; MEMBUS_FAULT_EN flags stores to ROM/IN.
// Latency accept->rsp_valid 2 cycles; req_ready drops during ISSUE so at most one accept per 2 cycles.
module memory_bus_ctrl
    import membus_pkg::*;
#(
    parameter int unsigned ROM_TOP = ROM_TOP_DEF,
    parameter int unsigned RW_TOP  = RW_TOP_DEF,
    parameter int unsigned OUT_TOP = OUT_TOP_DEF,
    parameter int unsigned NUM_OUT = 16,
    parameter int unsigned NUM_IN  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [7:0]             req_addr,
    input  logic [7:0]             req_wdata,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_fault,
    output logic [7:0]             rom_addr,
    input  logic [7:0]             rom_data,
    output logic [7:0]             rw_address,
    output logic [7:0]             rw_data_in,
    output logic                   rw_write,
    input  logic [7:0]             rw_data_out,
    output logic [8*NUM_OUT-1:0]   port_out,
    input  logic [8*NUM_IN-1:0]    port_in
);

    localparam int unsigned IDX_W = $clog2((NUM_OUT > NUM_IN) ? NUM_OUT : NUM_IN);

    state_t                    state_q;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic                      rw_write_q;
    logic [7:0]                addr_q;
    logic [7:0]                wdata_q;
    logic                      write_q;
    region_t                   region_q;
    logic [IDX_W-1:0]          idx_q;
    logic [7:0]                in_samp_q;
    logic [NUM_OUT-1:0][7:0]   port_out_q;
    logic [NUM_IN-1:0][7:0]    port_in_a;

    region_t                   dec_region;
    logic [IDX_W-1:0]          dec_idx;
    logic                      accept;

    membus_decode #(
        .ROM_TOP (ROM_TOP),
        .RW_TOP  (RW_TOP),
        .OUT_TOP (OUT_TOP),
        .IDX_W   (IDX_W)
    ) u_decode (
        .addr_i   (req_addr),
        .region_o (dec_region),
        .idx_o    (dec_idx)
    );

    assign port_in_a = port_in;
    assign accept    = req_valid && req_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rw_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            region_q    <= REG_ROM;
            idx_q       <= '0;
            in_samp_q   <= '0;
            port_out_q  <= '0;
        end else begin
            rw_write_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        state_q     <= ST_ISSUE;
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        write_q     <= req_write;
                        region_q    <= dec_region;
                        idx_q       <= dec_idx;
                        rw_write_q  <= req_write && (dec_region == REG_RW);
                    end else begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q     <= ST_RESP;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    if (write_q && (region_q == REG_OUT)) begin
                        port_out_q[idx_q] <= wdata_q;
                    end
                    if (region_q == REG_IN) begin
                        in_samp_q <= port_in_a[idx_q];
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // ROM and RAM answer one cycle after ISSUE, so load data is steered straight from their outputs.
    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid_q && !write_q) begin
            case (region_q)
                REG_ROM: rsp_rdata = rom_data;
                REG_RW:  rsp_rdata = rw_data_out;
                REG_OUT: rsp_rdata = port_out_q[idx_q];
                REG_IN:  rsp_rdata = in_samp_q;
                default: rsp_rdata = '0;
            endcase
        end
    end

`ifdef MEMBUS_FAULT_EN
    assign rsp_fault = rsp_valid_q && write_q && ((region_q == REG_ROM) || (region_q == REG_IN));
`else
    assign rsp_fault = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rw_write   = rw_write_q;
    assign rw_address = addr_q;
    assign rom_addr   = addr_q;
    assign rw_data_in = wdata_q;
    assign port_out   = port_out_q;

endmodule
